// File: rtl/glitch_sweep_ctrl.sv
// Sweep scheduler for the glitch datapath: walks an (offset, duration) grid,
// repeating each point, and sequences reset / settle / arm / wait / log per attempt.
module glitch_sweep_ctrl #(
  parameter int W           = 32,
  parameter int SETTLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 65536,
  parameter int RW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          stop_on_hit,
  input  logic [W-1:0]  off_start,
  input  logic [W-1:0]  off_end,
  input  logic [W-1:0]  off_step,
  input  logic [W-1:0]  dur_start,
  input  logic [W-1:0]  dur_end,
  input  logic [W-1:0]  dur_step,
  input  logic [RW-1:0] repeat_n,
  input  logic          result_valid,
  input  logic          result_hit,
  output logic          target_reset,
  output logic          start_offset_counter,
  output logic [W-1:0]  glitch_offset,
  output logic [W-1:0]  glitch_duration,
  output logic          busy,
  output logic          done,
  output logic          att_valid,
  output logic          att_hit,
  output logic          att_timeout
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_ARM, S_WAIT_RES, S_LOG, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  cfg_off_start, cfg_off_end, cfg_off_step;
  logic [W-1:0]  cfg_dur_start, cfg_dur_end, cfg_dur_step;
  logic [RW-1:0] cfg_repeat;
  logic          cfg_stop_on_hit;
  logic [W-1:0]  cur_off, cur_dur;
  logic [RW-1:0] rep;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timer;
  logic          last_hit;

  logic [W:0]    nxt_off_w, nxt_dur_w;
  logic          off_wrap, dur_wrap;
  logic [RW-1:0] rep_eff;
  logic          rep_more;
  logic [TW-1:0] timer_next;
  logic          timed_out;

  // The extra carry bit catches steps that overflow W bits, which end the axis
  // just like stepping past its end value; an inverted range collapses to its start.
  assign nxt_off_w  = {1'b0, cur_off} + {1'b0, cfg_off_step};
  assign nxt_dur_w  = {1'b0, cur_dur} + {1'b0, cfg_dur_step};
  assign off_wrap   = nxt_off_w[W] || (nxt_off_w[W-1:0] > cfg_off_end) || (cfg_off_step == '0);
  assign dur_wrap   = nxt_dur_w[W] || (nxt_dur_w[W-1:0] > cfg_dur_end) || (cfg_dur_step == '0);
  assign rep_eff    = (cfg_repeat == '0) ? RW'(1) : cfg_repeat;
  assign rep_more   = ({1'b0, rep} + (RW+1)'(1)) < {1'b0, rep_eff};
  assign timer_next = timer + TW'(1);
  assign timed_out  = (timer_next == TIMEOUT_LAST);

  assign glitch_offset   = cur_off;
  assign glitch_duration = cur_dur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      cfg_off_start        <= '0;
      cfg_off_end          <= '0;
      cfg_off_step         <= '0;
      cfg_dur_start        <= '0;
      cfg_dur_end          <= '0;
      cfg_dur_step         <= '0;
      cfg_repeat           <= '0;
      cfg_stop_on_hit      <= 1'b0;
      cur_off              <= '0;
      cur_dur              <= '0;
      rep                  <= '0;
      settle_cnt           <= '0;
      timer                <= '0;
      last_hit             <= 1'b0;
      target_reset         <= 1'b0;
      start_offset_counter <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      att_valid            <= 1'b0;
      att_hit              <= 1'b0;
      att_timeout          <= 1'b0;
    end else begin
      target_reset         <= 1'b0;
      start_offset_counter <= 1'b0;
      done                 <= 1'b0;
      att_valid            <= 1'b0;
      att_hit              <= 1'b0;
      att_timeout          <= 1'b0;

      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cfg_off_start   <= off_start;
              cfg_off_end     <= off_end;
              cfg_off_step    <= off_step;
              cfg_dur_start   <= dur_start;
              cfg_dur_end     <= dur_end;
              cfg_dur_step    <= dur_step;
              cfg_repeat      <= repeat_n;
              cfg_stop_on_hit <= stop_on_hit;
              cur_off         <= off_start;
              cur_dur         <= dur_start;
              rep             <= '0;
              target_reset    <= 1'b1;
              busy            <= 1'b1;
              state           <= S_RST;
            end
          end
          S_RST: begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              start_offset_counter <= 1'b1;
              state                <= S_ARM;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          S_ARM: begin
            timer <= '0;
            state <= S_WAIT_RES;
          end
          S_WAIT_RES: begin
            // A result arriving on the timeout cycle still counts as a real outcome.
            if (result_valid) begin
              att_valid <= 1'b1;
              att_hit   <= result_hit;
              last_hit  <= result_hit;
              state     <= S_LOG;
            end else if (timed_out) begin
              att_valid   <= 1'b1;
              att_timeout <= 1'b1;
              last_hit    <= 1'b0;
              state       <= S_LOG;
            end else begin
              timer <= timer_next;
            end
          end
          S_LOG: begin
            if (cfg_stop_on_hit && last_hit) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (rep_more) begin
              rep          <= rep + RW'(1);
              target_reset <= 1'b1;
              state        <= S_RST;
            end else begin
              rep <= '0;
              if (!off_wrap) begin
                cur_off      <= nxt_off_w[W-1:0];
                target_reset <= 1'b1;
                state        <= S_RST;
              end else begin
                cur_off <= cfg_off_start;
                if (dur_wrap) begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  cur_dur      <= nxt_dur_w[W-1:0];
                  target_reset <= 1'b1;
                  state        <= S_RST;
                end
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
